// File: rtl/collision_resolver.sv
// collision_resolver
//   Resolves ball-ball collisions and pocketings once per video frame.
//   Overlap requests are filtered by a per-frame done mask. The two lowest
//   remaining requesters form a pair, which passes through
//   ARMED -> CAPTURE -> RESOLVE. A lone requester that coincides with a
//   pocket request is scored in ARMED.
//
// Ports
//   clk               system clock, rising edge
//   resetN            synchronous reset, active HIGH despite the name
//   startOfFrame      one-cycle frame pulse, re-arms the block
//   ball_requests     per-ball overlap request
//   hole_requests     per-pocket overlap request
//   velocitiesX/Y     current signed ball velocities
//   topLeftXs/Ys      current unsigned ball positions
//   collisions        one-cycle load strobe per ball
//   newVelocitiesX/Y  velocity to load, held between strobes
//   ball_scored       one-cycle pocket strobe per ball
//   ballIn            one-cycle pulse when a non-cue ball is pocketed
//   no_moving_flag    registered: every input velocity is zero
//   busy              a pair is in flight (CAPTURE or RESOLVE)
//   pair_count        collisions resolved in the current frame
module collision_resolver #(
    parameter int NUM_BALLS      = 11,
    parameter int NUM_HOLES      = 6,
    parameter int VEL_W          = 32,
    parameter int COORD_W        = 11,
    parameter int RECOIL         = 20,
    parameter int OVERLAP_RECOIL = 30,
    parameter int MAX_PAIRS      = 4
) (
    input  logic                              clk,
    input  logic                              resetN,
    input  logic                              startOfFrame,
    input  logic        [NUM_BALLS-1:0]       ball_requests,
    input  logic        [NUM_HOLES-1:0]       hole_requests,
    input  logic signed [VEL_W-1:0]           velocitiesX    [NUM_BALLS],
    input  logic signed [VEL_W-1:0]           velocitiesY    [NUM_BALLS],
    input  logic        [COORD_W-1:0]         topLeftXs      [NUM_BALLS],
    input  logic        [COORD_W-1:0]         topLeftYs      [NUM_BALLS],
    output logic        [NUM_BALLS-1:0]       collisions,
    output logic signed [VEL_W-1:0]           newVelocitiesX [NUM_BALLS],
    output logic signed [VEL_W-1:0]           newVelocitiesY [NUM_BALLS],
    output logic        [NUM_BALLS-1:0]       ball_scored,
    output logic                              ballIn,
    output logic                              no_moving_flag,
    output logic                              busy,
    output logic [$clog2(MAX_PAIRS+1)-1:0]    pair_count
);

    localparam int IDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam int PC_W  = $clog2(MAX_PAIRS + 1);
    localparam logic [PC_W-1:0]         MAX_PC     = PC_W'(MAX_PAIRS);
    localparam logic signed [VEL_W:0]   RECOIL_EXT = (VEL_W+1)'(RECOIL);
    localparam logic signed [VEL_W-1:0] OVR_POS    = VEL_W'(OVERLAP_RECOIL);
    localparam logic signed [VEL_W-1:0] OVR_NEG    = -OVR_POS;

    typedef enum logic [1:0] {ARMED, CAPTURE, RESOLVE, SPENT} state_t;

    // Clamp a one-bit-wider sum into the signed VEL_W range.
    function automatic logic signed [VEL_W-1:0] sat(input logic signed [VEL_W:0] s);
        if (s[VEL_W] != s[VEL_W-1])
            sat = s[VEL_W] ? {1'b1, {(VEL_W-1){1'b0}}} : {1'b0, {(VEL_W-1){1'b1}}};
        else
            sat = s[VEL_W-1:0];
    endfunction

    // New velocity of the lower-index ball on one axis.
    function automatic logic signed [VEL_W-1:0] resolve_a(
        input logic                      stationary,
        input logic signed [VEL_W-1:0]   v_b,
        input logic        [COORD_W-1:0] c_a,
        input logic        [COORD_W-1:0] c_b
    );
        logic signed [VEL_W:0] vb_ext;
        vb_ext = {v_b[VEL_W-1], v_b};
        if (stationary)
            resolve_a = (c_a < c_b) ? OVR_NEG : OVR_POS;
        else if (c_a < c_b)
            resolve_a = sat(vb_ext - RECOIL_EXT);
        else
            resolve_a = sat(vb_ext + RECOIL_EXT);
    endfunction

    // New velocity of the higher-index ball on one axis.
    function automatic logic signed [VEL_W-1:0] resolve_b(
        input logic                      stationary,
        input logic signed [VEL_W-1:0]   v_a,
        input logic        [COORD_W-1:0] c_a,
        input logic        [COORD_W-1:0] c_b
    );
        if (stationary)
            resolve_b = (c_a < c_b) ? OVR_POS : OVR_NEG;
        else
            resolve_b = v_a;
    endfunction

    state_t                state, state_next;
    logic                  sof_pending;
    logic [NUM_BALLS-1:0]  done_mask;
    logic [NUM_BALLS-1:0]  eff;
    logic                  a_found, b_found;
    logic [IDX_W-1:0]      a_idx, b_idx;
    logic                  do_capture, do_pocket, do_resolve, do_clear;
    logic                  all_still;

    logic [IDX_W-1:0]         a_idx_p0, b_idx_p0;
    logic signed [VEL_W-1:0]  va_x_p0, va_y_p0, vb_x_p0, vb_y_p0;
    logic [COORD_W-1:0]       ca_x_p0, ca_y_p0, cb_x_p0, cb_y_p0;
    logic                     stationary_p0;
    logic signed [VEL_W-1:0]  na_x_p1, na_y_p1, nb_x_p1, nb_y_p1;

    assign eff  = ball_requests & ~done_mask;
    assign busy = (state == CAPTURE) || (state == RESOLVE);

    // Lowest and next-lowest unmasked requesters.
    always_comb begin
        a_found = 1'b0;
        b_found = 1'b0;
        a_idx   = '0;
        b_idx   = '0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (eff[i]) begin
                if (!a_found) begin
                    a_found = 1'b1;
                    a_idx   = IDX_W'(i);
                end else if (!b_found) begin
                    b_found = 1'b1;
                    b_idx   = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        all_still = 1'b1;
        for (int i = 0; i < NUM_BALLS; i++)
            if (velocitiesX[i] != '0 || velocitiesY[i] != '0) all_still = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (resetN) state <= ARMED;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_capture = 1'b0;
        do_pocket  = 1'b0;
        do_resolve = 1'b0;
        do_clear   = 1'b0;
        case (state)
            ARMED: begin
                // A frame pulse wins over any capture or pocket on the same edge.
                if (startOfFrame) begin
                    do_clear = 1'b1;
                end else if (a_found && b_found && pair_count < MAX_PC) begin
                    do_capture = 1'b1;
                    state_next = CAPTURE;
                end else if (a_found && !b_found && |hole_requests) begin
                    do_pocket = 1'b1;
                end
            end
            CAPTURE: state_next = RESOLVE;
            RESOLVE: begin
                do_resolve = 1'b1;
                // A frame pulse seen while in flight clears only once the pair is out.
                if (startOfFrame || sof_pending) begin
                    do_clear   = 1'b1;
                    state_next = ARMED;
                end else if (pair_count + PC_W'(1) >= MAX_PC) begin
                    state_next = SPENT;
                end else begin
                    state_next = ARMED;
                end
            end
            SPENT: begin
                if (startOfFrame) begin
                    do_clear   = 1'b1;
                    state_next = ARMED;
                end
            end
            default: state_next = ARMED;
        endcase
    end

    assign stationary_p0 = (va_x_p0 == '0) && (va_y_p0 == '0) &&
                           (vb_x_p0 == '0) && (vb_y_p0 == '0);

    // Stage p0: latch the pair at capture. Stage p1: computed results.
    always_ff @(posedge clk) begin
        if (do_capture) begin
            a_idx_p0 <= a_idx;
            b_idx_p0 <= b_idx;
            va_x_p0  <= velocitiesX[a_idx];
            va_y_p0  <= velocitiesY[a_idx];
            vb_x_p0  <= velocitiesX[b_idx];
            vb_y_p0  <= velocitiesY[b_idx];
            ca_x_p0  <= topLeftXs[a_idx];
            ca_y_p0  <= topLeftYs[a_idx];
            cb_x_p0  <= topLeftXs[b_idx];
            cb_y_p0  <= topLeftYs[b_idx];
        end
        if (state == CAPTURE) begin
            na_x_p1 <= resolve_a(stationary_p0, vb_x_p0, ca_x_p0, cb_x_p0);
            na_y_p1 <= resolve_a(stationary_p0, vb_y_p0, ca_y_p0, cb_y_p0);
            nb_x_p1 <= resolve_b(stationary_p0, va_x_p0, ca_x_p0, cb_x_p0);
            nb_y_p1 <= resolve_b(stationary_p0, va_y_p0, ca_y_p0, cb_y_p0);
        end
    end

    // Output stage: strobes, frame bookkeeping and held velocities.
    always_ff @(posedge clk) begin
        if (resetN) begin
            sof_pending    <= 1'b0;
            done_mask      <= '0;
            pair_count     <= '0;
            collisions     <= '0;
            ball_scored    <= '0;
            ballIn         <= 1'b0;
            no_moving_flag <= 1'b1;
            for (int i = 0; i < NUM_BALLS; i++) begin
                newVelocitiesX[i] <= '0;
                newVelocitiesY[i] <= '0;
            end
        end else begin
            collisions     <= '0;
            ball_scored    <= '0;
            ballIn         <= 1'b0;
            no_moving_flag <= all_still;

            if (do_resolve)
                sof_pending <= 1'b0;
            else if (state == CAPTURE && startOfFrame)
                sof_pending <= 1'b1;

            if (do_clear) begin
                done_mask  <= '0;
                pair_count <= '0;
            end else if (do_resolve) begin
                done_mask[a_idx_p0] <= 1'b1;
                done_mask[b_idx_p0] <= 1'b1;
                pair_count          <= pair_count + PC_W'(1);
            end else if (do_pocket) begin
                done_mask[a_idx] <= 1'b1;
            end

            if (do_resolve) begin
                collisions[a_idx_p0]     <= 1'b1;
                collisions[b_idx_p0]     <= 1'b1;
                newVelocitiesX[a_idx_p0] <= na_x_p1;
                newVelocitiesY[a_idx_p0] <= na_y_p1;
                newVelocitiesX[b_idx_p0] <= nb_x_p1;
                newVelocitiesY[b_idx_p0] <= nb_y_p1;
            end

            if (do_pocket) begin
                ball_scored[a_idx] <= 1'b1;
                ballIn             <= (a_idx != '0);
            end
        end
    end

endmodule

// File: tb/tb_collision_resolver.sv
// tb_collision_resolver
//   Self-checking bench for collision_resolver: a table of single-pair
//   vectors with hand-derived results, hand-written multi-cycle sequences,
//   and randomized frames checked against a behavioural model.
module tb_collision_resolver;

    localparam int NB = 11;
    localparam int NH = 6;

    logic               clk = 1'b0;
    logic               resetN;
    logic               startOfFrame;
    logic [NB-1:0]      ball_requests;
    logic [NH-1:0]      hole_requests;
    logic signed [31:0] vx [NB];
    logic signed [31:0] vy [NB];
    logic [10:0]        tx [NB];
    logic [10:0]        ty [NB];
    logic [NB-1:0]      collisions;
    logic signed [31:0] nvx [NB];
    logic signed [31:0] nvy [NB];
    logic [NB-1:0]      ball_scored;
    logic               ballIn;
    logic               no_moving_flag;
    logic               busy;
    logic [2:0]         pair_count;

    collision_resolver dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .ball_requests(ball_requests), .hole_requests(hole_requests),
        .velocitiesX(vx), .velocitiesY(vy), .topLeftXs(tx), .topLeftYs(ty),
        .collisions(collisions), .newVelocitiesX(nvx), .newVelocitiesY(nvy),
        .ball_scored(ball_scored), .ballIn(ballIn),
        .no_moving_flag(no_moving_flag), .busy(busy), .pair_count(pair_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    longint exp_x [NB];
    longint exp_y [NB];

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    endtask

    function automatic longint clamp32(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    // Reference: collision rules applied to the current inputs of balls lo < hi.
    task automatic model_pair(input int lo, input int hi);
        longint ax, ay, bx, by;
        bit still;
        ax = longint'(vx[lo]); ay = longint'(vy[lo]);
        bx = longint'(vx[hi]); by = longint'(vy[hi]);
        still = (ax == 0) && (ay == 0) && (bx == 0) && (by == 0);
        if (still) begin
            exp_x[lo] = (tx[lo] < tx[hi]) ? -30 : 30;
            exp_x[hi] = -exp_x[lo];
            exp_y[lo] = (ty[lo] < ty[hi]) ? -30 : 30;
            exp_y[hi] = -exp_y[lo];
        end else begin
            exp_x[lo] = clamp32(bx + ((tx[lo] < tx[hi]) ? -20 : 20));
            exp_y[lo] = clamp32(by + ((ty[lo] < ty[hi]) ? -20 : 20));
            exp_x[hi] = ax;
            exp_y[hi] = ay;
        end
    endtask

    task automatic check_all_nv(input string tag);
        int bad = 0;
        for (int i = 0; i < NB; i++)
            if (longint'(nvx[i]) != exp_x[i] || longint'(nvy[i]) != exp_y[i]) bad++;
        check($sformatf("%s_nv_all_wrong_entries", tag), bad, 0);
    endtask

    // All tasks start and end just after a falling edge.
    task automatic pulse_sof();
        startOfFrame = 1'b1;
        @(posedge clk); @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    task automatic run_pair(input int lo, input int hi, input int exp_pc, input string tag);
        logic [NB-1:0] req;
        req = '0; req[lo] = 1'b1; req[hi] = 1'b1;
        ball_requests = req;
        @(posedge clk); @(negedge clk);
        check({tag, "_busy"}, busy, 1);
        ball_requests = '0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check({tag, "_coll"}, collisions, req);
        check({tag, "_pc"}, pair_count, exp_pc);
        model_pair(lo, hi);
        check_all_nv(tag);
    endtask

    typedef struct {
        int a, b;
        int vax, vay, vbx, vby;
        int xa, ya, xb, yb;
        int eax, eay, ebx, eby;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int bad;
        int frees [$];
        int lo, hi, k, np, pc;
        logic [NB-1:0] req;

        tbl[0] = '{2, 5,   40, 0, 0, 0,   100, 200, 116, 200,   -20, 20, 40, 0};
        tbl[1] = '{3, 4,   0, 0, 0, 0,    50, 60, 40, 70,       30, -30, -30, 30};
        tbl[2] = '{1, 8,   5, -7, 32'sh7FFFFFF0, 32'sh80000008,  300, 10, 200, 20,
                   32'sh7FFFFFFF, 32'sh80000000, 5, -7};
        tbl[3] = '{0, 10,  0, 0, 0, 0,    77, 88, 77, 88,       30, 30, -30, -30};
        tbl[4] = '{6, 9,   -15, 25, 7, -3,  10, 50, 20, 40,     -13, 17, -15, 25};
        tbl[5] = '{5, 7,   0, 0, 0, 1,    5, 9, 6, 8,           -20, 21, 0, 0};

        resetN = 1'b1; startOfFrame = 1'b0; ball_requests = '0; hole_requests = '0;
        for (int i = 0; i < NB; i++) begin
            vx[i] = 0; vy[i] = 0; tx[i] = 11'(i * 40); ty[i] = 11'(i * 20);
            exp_x[i] = 0; exp_y[i] = 0;
        end
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("rst_coll", collisions, 0);
        check("rst_scored", ball_scored, 0);
        check("rst_ballIn", ballIn, 0);
        check("rst_busy", busy, 0);
        check("rst_pc", pair_count, 0);
        check("rst_nomove", no_moving_flag, 1);
        check_all_nv("rst");
        resetN = 1'b0;
        @(posedge clk); @(negedge clk);

        // Table-driven single pairs, one per frame.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < NB; i++) begin vx[i] = 0; vy[i] = 0; end
            vx[tbl[t].a] = tbl[t].vax; vy[tbl[t].a] = tbl[t].vay;
            vx[tbl[t].b] = tbl[t].vbx; vy[tbl[t].b] = tbl[t].vby;
            tx[tbl[t].a] = 11'(tbl[t].xa); ty[tbl[t].a] = 11'(tbl[t].ya);
            tx[tbl[t].b] = 11'(tbl[t].xb); ty[tbl[t].b] = 11'(tbl[t].yb);
            pulse_sof();
            run_pair(tbl[t].a, tbl[t].b, 1, $sformatf("tbl%0d", t));
            check($sformatf("tbl%0d_ax", t), nvx[tbl[t].a], tbl[t].eax);
            check($sformatf("tbl%0d_ay", t), nvy[tbl[t].a], tbl[t].eay);
            check($sformatf("tbl%0d_bx", t), nvx[tbl[t].b], tbl[t].ebx);
            check($sformatf("tbl%0d_by", t), nvy[tbl[t].b], tbl[t].eby);
        end

        // no_moving_flag follows the inputs one edge later.
        check("nomove_low", no_moving_flag, 0);
        for (int i = 0; i < NB; i++) begin vx[i] = 0; vy[i] = 0; end
        @(posedge clk); @(negedge clk);
        check("nomove_high", no_moving_flag, 1);
        vy[3] = -1;
        @(posedge clk); @(negedge clk);
        check("nomove_low2", no_moving_flag, 0);

        // Three requesters held: (1,6) first, 9 alone stays idle.
        vx[1] = 12; vy[1] = -4; vx[6] = -9; vy[6] = 3;
        pulse_sof();
        req = '0; req[1] = 1'b1; req[6] = 1'b1; req[9] = 1'b1;
        ball_requests = req;
        @(posedge clk); @(posedge clk); @(posedge clk); @(negedge clk);
        req[9] = 1'b0;
        check("tri_coll", collisions, req);
        model_pair(1, 6);
        check_all_nv("tri");
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); @(negedge clk);
            if (collisions != 0 || ball_scored != 0 || busy != 0) bad++;
        end
        check("tri_idle_cycles_active", bad, 0);
        check("tri_pc", pair_count, 1);
        ball_requests = '0;

        // Pocketing: ball 7 then cue ball.
        pulse_sof();
        ball_requests = NB'(1 << 7); hole_requests = NH'(1 << 2);
        @(posedge clk); @(negedge clk);
        check("pock7_scored", ball_scored, 1 << 7);
        check("pock7_ballIn", ballIn, 1);
        @(posedge clk); @(negedge clk);
        check("pock7_masked_scored", ball_scored, 0);
        check("pock7_masked_ballIn", ballIn, 0);
        ball_requests = NB'(1);
        @(posedge clk); @(negedge clk);
        check("pock0_scored", ball_scored, 1);
        check("pock0_ballIn", ballIn, 0);
        ball_requests = '0; hole_requests = '0;

        // Four pairs fill the frame, the fifth waits for the next frame.
        for (int i = 0; i < NB; i++) begin
            vx[i] = 32'(i * 3 - 10); vy[i] = 32'(7 - i);
        end
        pulse_sof();
        for (int p = 0; p < 4; p++) run_pair(2 * p, 2 * p + 1, p + 1, $sformatf("max%0d", p));
        check("spent_busy", busy, 0);
        req = '0; req[8] = 1'b1; req[9] = 1'b1;
        ball_requests = req;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); @(negedge clk);
            if (collisions != 0 || busy != 0) bad++;
        end
        check("spent_ignored_cycles", bad, 0);
        check("spent_pc", pair_count, 4);
        pulse_sof();
        @(posedge clk); @(posedge clk); @(posedge clk); @(negedge clk);
        check("fifth_coll", collisions, req);
        check("fifth_pc", pair_count, 1);
        model_pair(8, 9);
        check_all_nv("fifth");
        ball_requests = '0;

        // startOfFrame during CAPTURE: pair still strobes, count ends at 0.
        pulse_sof();
        run_pair(0, 1, 1, "sofcap_pre");
        req = '0; req[2] = 1'b1; req[3] = 1'b1;
        ball_requests = req;
        @(posedge clk); @(negedge clk);
        ball_requests = '0; startOfFrame = 1'b1;
        @(posedge clk); @(negedge clk);
        startOfFrame = 1'b0;
        @(posedge clk); @(negedge clk);
        check("sofcap_coll", collisions, req);
        check("sofcap_pc", pair_count, 0);
        check("sofcap_busy", busy, 0);
        model_pair(2, 3);
        check_all_nv("sofcap");
        // Done mask was cleared too: the same pair resolves again.
        run_pair(2, 3, 1, "sofcap_again");

        // Reset during RESOLVE: no strobe, everything back to reset values.
        req = '0; req[4] = 1'b1; req[5] = 1'b1;
        ball_requests = req;
        @(posedge clk); @(negedge clk);
        ball_requests = '0;
        @(posedge clk); @(negedge clk);
        resetN = 1'b1;
        @(posedge clk); @(negedge clk);
        resetN = 1'b0;
        for (int i = 0; i < NB; i++) begin exp_x[i] = 0; exp_y[i] = 0; end
        check("rstmid_coll", collisions, 0);
        check("rstmid_pc", pair_count, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_nomove", no_moving_flag, 1);
        check_all_nv("rstmid");
        @(posedge clk); @(negedge clk);
        check("rstmid_after_coll", collisions, 0);

        // Randomized frames against the model.
        for (int f = 0; f < 12; f++) begin
            pulse_sof();
            frees.delete();
            for (int i = 0; i < NB; i++) frees.push_back(i);
            np = $urandom_range(1, 4);
            pc = 0;
            for (int p = 0; p < np; p++) begin
                k = $urandom_range(0, frees.size() - 1);
                lo = frees[k]; frees.delete(k);
                k = $urandom_range(0, frees.size() - 1);
                hi = frees[k]; frees.delete(k);
                if (lo > hi) begin k = lo; lo = hi; hi = k; end
                for (int s = 0; s < 2; s++) begin
                    int ball;
                    ball = (s == 0) ? lo : hi;
                    for (int ax = 0; ax < 2; ax++) begin
                        logic signed [31:0] v;
                        case ($urandom_range(0, 5))
                            0, 1, 2: v = 0;
                            3:       v = 32'($urandom_range(0, 200)) - 32'd100;
                            4:       v = 32'h7FFFFFE0 + 32'($urandom_range(0, 31));
                            default: v = 32'h80000000 + 32'($urandom_range(0, 31));
                        endcase
                        if (ax == 0) vx[ball] = v; else vy[ball] = v;
                    end
                    tx[ball] = 11'($urandom_range(100, 103));
                    ty[ball] = 11'($urandom_range(100, 103));
                end
                pc++;
                run_pair(lo, hi, pc, $sformatf("rnd%0d_%0d", f, p));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
